// File: rtl/mult_ctrl_4bit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_ctrl_4bit_pkg
// Description : Shared state encodings and constants for the 4x4 sequential
//               shift-add multiplier controller and its adder datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_ctrl_4bit_pkg;

  // Operand width, fixed by the ripple adder datapath
  localparam int OPW = 4;

  // Counter value of the final CALC iteration
  localparam logic [1:0] ITER_LAST = 2'd3;

  // Controller states; encoding 2'd3 is unused and recovers to IDLE
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : mult_ctrl_4bit_pkg
`default_nettype wire

// File: rtl/ripple_adder_4bit.sv
`default_nettype none
// ============================================================================
// Module      : ripple_adder_4bit
// Description : Combinational 4-bit ripple-carry adder; 5-bit result carries
//               the final carry out in bit 4.
// Revision    : 1.0 - initial release
// ============================================================================
module ripple_adder_4bit
  import mult_ctrl_4bit_pkg::*;
(
  input  logic [OPW-1:0] num1,
  input  logic [OPW-1:0] num2,
  output logic [OPW:0]   result
);

  logic [OPW:0]   carry;
  logic [OPW-1:0] sum;

  assign carry[0] = 1'b0;

  // One full-adder cell per bit, carry rippling upward
  for (genvar i = 0; i < OPW; i++) begin : g_bit
    assign sum[i]     = num1[i] ^ num2[i] ^ carry[i];
    assign carry[i+1] = (num1[i] & num2[i]) | (carry[i] & (num1[i] ^ num2[i]));
  end

  assign result = {carry[OPW], sum};

endmodule : ripple_adder_4bit
`default_nettype wire

// File: rtl/mult_ctrl_4bit.sv
`default_nettype none
// ============================================================================
// Module      : mult_ctrl_4bit
// Description : Sequential 4x4 unsigned shift-add multiplier controller.
//               Reuses one 4-bit ripple adder over four iterations; the
//               8-bit product {acc_hi, q} is valid in the DONE cycle and holds
//               until the next accepted start.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_ctrl_4bit
  import mult_ctrl_4bit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OPW-1:0]   multiplicand,
  input  logic [OPW-1:0]   multiplier,
  output logic             busy,
  output logic             done,
  output logic [2*OPW-1:0] product
);

  state_t         state;
  state_t         next_state;
  logic [OPW-1:0] m_reg;
  logic [OPW-1:0] acc_hi;
  logic [OPW-1:0] q;
  logic [1:0]     cnt;
  logic [OPW-1:0] addend;
  logic [OPW:0]   sum;

  // Add the multiplicand only when the current multiplier LSB is set
  assign addend = q[0] ? m_reg : '0;

  ripple_adder_4bit u_adder (
    .num1   (acc_hi),
    .num2   (addend),
    .result (sum)
  );

  // The product is simply the concatenated shift register
  assign product = {acc_hi, q};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Operand load on accept, then one shift-add iteration per CALC cycle;
  // the adder carry lands in acc_hi[3] through the 9-bit right shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reg  <= '0;
      acc_hi <= '0;
      q      <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_reg  <= multiplicand;
            q      <= multiplier;
            acc_hi <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          {acc_hi, q} <= {sum, q[OPW-1:1]};
          cnt         <= cnt + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and status outputs
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == ITER_LAST) begin
          next_state = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule : mult_ctrl_4bit
`default_nettype wire
